// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// Widths, source encoding and the round-robin helper used by wb_arbiter.
package wb_arbiter_pkg;

  localparam int WB_DATA_WIDTH   = 32;
  localparam int WB_ADDR_WIDTH   = 5;
  localparam int WB_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2,
    SRC_MDU  = 2'd3
  } src_e;

  // Round-robin points away from whichever long-latency source was just served.
  function automatic src_e rr_other(input src_e won);
    return (won == SRC_LSU) ? SRC_MDU : SRC_LSU;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer-side handshakes (ALU/LSU/MDU) and the register-file write port.
// slave = arbiter view, master = producers/register-file view.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH
);
  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;

  logic                  mdu_valid;
  logic                  mdu_ready;
  logic [ADDR_WIDTH-1:0] mdu_rd;
  logic [DATA_WIDTH-1:0] mdu_data;

  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_rd;
  logic [DATA_WIDTH-1:0] rf_wdata;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  mdu_valid, mdu_rd, mdu_data,
    output lsu_ready, mdu_ready,
    output rf_we, rf_rd, rf_wdata
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output mdu_valid, mdu_rd, mdu_data,
    input  lsu_ready, mdu_ready,
    input  rf_we, rf_rd, rf_wdata
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Per-register busy bits for outstanding long-latency writes.
// Set on issue, cleared on write-back handshake; set wins on a same-index collision.
module wb_scoreboard
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  input  logic [ADDR_WIDTH-1:0] q1_idx,
  input  logic [ADDR_WIDTH-1:0] q2_idx,
  output logic                  q1_busy,
  output logic                  q2_busy
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;  // x0 never becomes busy
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign q1_busy = busy_q[q1_idx] & (q1_idx != '0);
  assign q2_busy = busy_q[q2_idx] & (q2_idx != '0);

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU > {LSU, MDU}, registered write port,
// starvation-driven ALU stall and RAW busy scoreboard. WB_RR_ARB_EN selects round-robin LSU/MDU.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH   = WB_ADDR_WIDTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_arbiter_if.slave           bus,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  alu_stall_req
);

  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic grant_lsu, grant_mdu;
  logic hs_lsu, hs_mdu, hs_any;

`ifdef WB_RR_ARB_EN
  src_e ptr_q, ptr_d;

  always_comb begin
    grant_lsu = bus.lsu_valid & (~bus.mdu_valid | (ptr_q == SRC_LSU));
    grant_mdu = bus.mdu_valid & (~bus.lsu_valid | (ptr_q == SRC_MDU));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs_lsu)      ptr_d = rr_other(SRC_LSU);
    else if (hs_mdu) ptr_d = rr_other(SRC_MDU);
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= SRC_LSU;
    else      ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant_lsu = bus.lsu_valid;
    grant_mdu = bus.mdu_valid & ~bus.lsu_valid;
  end
`endif

  // Readies are gated by reset so nothing in flight is consumed while held.
  assign hs_lsu        = rst & ~bus.alu_valid & grant_lsu;
  assign hs_mdu        = rst & ~bus.alu_valid & grant_mdu;
  assign hs_any        = hs_lsu | hs_mdu;
  assign bus.lsu_ready = hs_lsu;
  assign bus.mdu_ready = hs_mdu;

  src_e                  sel;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    sel      = SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (bus.alu_valid) begin
      sel      = SRC_ALU;
      sel_rd   = bus.alu_rd;
      sel_data = bus.alu_data;
    end else if (hs_lsu) begin
      sel      = SRC_LSU;
      sel_rd   = bus.lsu_rd;
      sel_data = bus.lsu_data;
    end else if (hs_mdu) begin
      sel      = SRC_MDU;
      sel_rd   = bus.mdu_rd;
      sel_data = bus.mdu_data;
    end
  end

  // Write port: address/data only move on a real write, so x0 results leave them untouched.
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  always_comb begin
    rf_we_d    = (sel != SRC_NONE) && (sel_rd != '0);
    rf_rd_d    = rf_we_d ? sel_rd   : rf_rd_q;
    rf_wdata_d = rf_we_d ? sel_data : rf_wdata_q;
  end

  // Starvation: count cycles a long-latency result is blocked by the ALU.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_q, stall_d;

  always_comb begin
    cnt_d = cnt_q;
    if (hs_any)
      cnt_d = '0;
    else if ((bus.lsu_valid | bus.mdu_valid) & bus.alu_valid & (cnt_q != CNT_MAX))
      cnt_d = cnt_q + CNT_W'(1);
    stall_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      cnt_q      <= '0;
      stall_q    <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      cnt_q      <= cnt_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.rf_we     = rf_we_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign alu_stall_req = stall_q;

  wb_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (iss_valid),
    .set_idx (iss_rd),
    .clr_en  (hs_any),
    .clr_idx (hs_lsu ? bus.lsu_rd : bus.mdu_rd),
    .q1_idx  (rs1),
    .q2_idx  (rs2),
    .q1_busy (rs1_busy),
    .q2_busy (rs2_busy)
  );

endmodule
